// File: rtl/axis_deadlock_block_detector.sv
// axis_deadlock_block_detector: sticky deadlock flag after a stable stall pattern persists CONFIRM_CYCLES samples.
// Optional DEADLOCK_BLOCK_CYCLE_CNT_EN adds o_block_cycles, a saturating count of cycles spent in BLOCKED.
module axis_deadlock_block_detector #(
    parameter int NUM_AXIS       = 4,
    parameter int NUM_INST       = 1,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NUM_AXIS-1:0] i_axis_block_sigs,
    input  logic [NUM_INST-1:0] i_inst_idle_sigs,
    input  logic [NUM_INST-1:0] i_inst_block_sigs,
    output logic                o_block,
    output logic [NUM_AXIS-1:0] o_block_axis_snap,
    output logic [1:0]          o_det_state
`ifdef DEADLOCK_BLOCK_CYCLE_CNT_EN
    ,
    output logic [31:0]         o_block_cycles
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, WATCH = 2'd1, BLOCKED = 2'd2} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_AXIS-1:0] r_snap, w_snap_nxt;
    logic                r_block, w_block_nxt;
    logic [NUM_AXIS-1:0] r_block_snap, w_block_snap_nxt;
    logic                w_stall_now;
    // every sub-instance idle means the kernel finished, which is not a deadlock
    assign w_stall_now = (|i_axis_block_sigs | |i_inst_block_sigs) & ~(&i_inst_idle_sigs);
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_snap_nxt       = r_snap;
        w_block_nxt      = r_block;
        w_block_snap_nxt = r_block_snap;
        case (r_state)
            IDLE: begin
                if (w_stall_now) begin
                    w_state_nxt = WATCH;
                    w_cnt_nxt   = CNT_W'(1);
                    w_snap_nxt  = i_axis_block_sigs;
                end
            end
            WATCH: begin
                if (!w_stall_now) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_axis_block_sigs != r_snap) begin
                    w_snap_nxt = i_axis_block_sigs;
                    w_cnt_nxt  = CNT_W'(1);
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt      = BLOCKED;
                    w_block_nxt      = 1'b1;
                    w_block_snap_nxt = r_snap;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            BLOCKED: w_state_nxt = BLOCKED;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_snap       <= '0;
            r_block      <= 1'b0;
            r_block_snap <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_snap       <= w_snap_nxt;
            r_block      <= w_block_nxt;
            r_block_snap <= w_block_snap_nxt;
        end
    end
    assign o_block           = r_block;
    assign o_block_axis_snap = r_block_snap;
    assign o_det_state       = r_state;
`ifdef DEADLOCK_BLOCK_CYCLE_CNT_EN
    logic [31:0] r_block_cycles;
    always_ff @(posedge i_clock) begin
        if (!i_reset)
            r_block_cycles <= '0;
        else if (r_state == BLOCKED && r_block_cycles != 32'hFFFF_FFFF)
            r_block_cycles <= r_block_cycles + 32'd1;
    end
    assign o_block_cycles = r_block_cycles;
`endif
endmodule

// File: doc/axis_deadlock_block_detector.md
Name: axis_deadlock_block_detector

Overview:
- Per-kernel deadlock detector; sits directly upstream of the kernel monitor top and produces the `block` flag it consumes.
- Watches AXIS-port block signals and sub-instance idle/block signals.
- Asserts a sticky `block` once the same stall pattern has held for a configurable confirmation window.
- Also latches which AXIS ports were blocked, for the downstream diagnosis report.

Parameters:
- NUM_AXIS, 4: width of axis_block_sigs (number of monitored AXIS ports).
- NUM_INST, 1: width of inst_idle_sigs / inst_block_sigs.
- CONFIRM_CYCLES, 16: consecutive stable stall samples needed to declare deadlock; legal range 2..65535.
- CNT_W, 16: width of the internal confirmation counter; must satisfy 2^CNT_W > CONFIRM_CYCLES.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- axis_block_sigs  in  NUM_AXIS  1 = kernel blocked on that AXIS port (no valid data in / not ready out).
- inst_idle_sigs  in  NUM_INST  1 = sub-instance idle.
- inst_block_sigs  in  NUM_INST  1 = sub-instance blocked.
- block  out  1  sticky deadlock flag.
- block_axis_snap  out  NUM_AXIS  axis_block_sigs pattern captured at the moment `block` is declared.
- det_state  out  2  FSM state: 0 IDLE, 1 WATCH, 2 BLOCKED.

Behaviour:
- Combinational stall_now = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs).
  - All sub-instances idle means the kernel is finished, not deadlocked.
- Reset (reset==0 at a rising edge): state=IDLE, cnt=0, snap=0, block=0, block_axis_snap=0, det_state=0. Takes priority over everything, including while in BLOCKED.
- IDLE:
  - stall_now=1 -> WATCH, cnt<=1, snap<=axis_block_sigs.
  - Otherwise remain in IDLE.
- WATCH (checks evaluated in priority order):
  - stall_now=0 -> IDLE, cnt<=0.
  - Else axis_block_sigs != snap (progress or pattern shift) -> stay in WATCH, snap<=axis_block_sigs, cnt<=1.
  - Else cnt == CONFIRM_CYCLES-1 -> BLOCKED, block<=1, block_axis_snap<=snap.
  - Else cnt<=cnt+1.
- BLOCKED:
  - Absorbing state; block=1 and block_axis_snap hold until reset.
  - Input changes are ignored.
- Latency: stall_now first sampled high at edge E0 with a constant pattern -> block is registered high at edge E0+CONFIRM_CYCLES-1, i.e. after CONFIRM_CYCLES consecutive stall samples.
- cnt never wraps; it is bounded by CONFIRM_CYCLES-1.
- inst_block_sigs-only stall: pattern comparison still uses axis_block_sigs only. A constant all-zero AXIS pattern is treated as stable.
- Simultaneous stall drop and pattern change in WATCH: the stall drop wins -> IDLE.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: DEADLOCK_BLOCK_CYCLE_CNT_EN.
- Defined:
  - Adds output block_cycles [31:0].
  - Reset value 0; increments by 1 on every edge while the state is BLOCKED.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
  - Reports how long the deadlock persisted before the simulation stopped.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset held low for 5 cycles with axis_block_sigs=4'b1111 -> block=0, det_state=0, block_axis_snap=0 throughout. After release, the first sample moves det_state to 1.
- CONFIRM_CYCLES=16, inst_idle=0, inst_block=0, axis_block_sigs=4'b0001 constant from edge 0 -> block rises exactly after edge 15, block_axis_snap=4'b0001, det_state=2, stays high for 100 further cycles.
- Same setup, but the pattern changes to 4'b0011 at edge 10 and is then held -> no block at edge 15; block rises after edge 25 with block_axis_snap=4'b0011.
- axis_block_sigs=4'b1000 for 15 samples, then 4'b0000 for 1 cycle, then 4'b1000 again -> det_state returns to 0, block stays 0, and a fresh 16-sample window starts.
- inst_idle_sigs=1 with axis_block_sigs=4'b0110 held for 50 cycles -> block=0, det_state=0. Then inst_idle_sigs=0 -> block after 16 samples.
- Deadlock in BLOCKED, then reset=0 for 1 edge -> block=0, block_axis_snap=0, det_state=0 on the next cycle. With DEADLOCK_BLOCK_CYCLE_CNT_EN: block_cycles counts 1,2,3… while blocked and reads 0 after reset.
